// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receiver slice.
//   - rx_state_t   : receiver FSM state encoding (ST_PARITY only exists when
//                    UART_RX_PARITY_EN is defined)
//   - DATA_BITS    : payload bits per frame
//   - clks_per_bit : system clocks per serial bit, truncating division
// Configuration macro: UART_RX_PARITY_EN (8E1 frames when defined, 8N1 otherwise).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if
//   Byte-strobe bundle between the UART receiver and its consumer
//   (the LED command parser).
//   rx_byte    : last correctly received byte
//   rx_valid   : one-cycle strobe, rx_byte updated this cycle
//   frame_err  : one-cycle strobe, stop bit sampled low
//   parity_err : one-cycle strobe, parity mismatch (0 when parity is disabled)
//   busy       : receiver is inside a frame or a break
//   master modport = receiver (drives), slave modport = consumer (reads).
interface uart_rx_core_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output rx_byte,
    output rx_valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    input rx_byte,
    input rx_valid,
    input frame_err,
    input parity_err,
    input busy
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for a single asynchronous bit.
//   clk  : destination clock
//   rstn : synchronous active-low reset; both flops load RESET_VAL
//   d    : asynchronous input
//   q    : synchronised output, two clk cycles behind d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  // Presetting to the line's idle level keeps the receiver from seeing a
  // phantom start edge straight out of reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Asynchronous UART receiver, 8N1 (or 8E1 with UART_RX_PARITY_EN defined).
//   Synchronises rx, rejects start-bit glitches, samples each bit near its
//   middle and reports each frame as exactly one strobe on the interface.
// Parameters
//   CLK_HZ : system clock frequency in Hz
//   BAUD   : line rate in bit/s (CLK_HZ/BAUD must be >= 4)
// Ports
//   clk   : system clock
//   rstn  : synchronous active-low reset
//   rx    : asynchronous serial input, idle high
//   rx_if : uart_rx_core_if.master (rx_byte, rx_valid, frame_err, parity_err, busy)
// Configuration macro: UART_RX_PARITY_EN
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 9600
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rx,
  uart_rx_core_if.master rx_if
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(CPB);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx_core: CLK_HZ/BAUD must be at least 4");
  end

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  // Next-state logic. The clock counter is cleared on every state change so
  // each bit period is timed from the previous sample point, never from a
  // free-running count. STOP returns to IDLE at mid-stop, which lets a start
  // edge that immediately follows the stop bit be caught.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            // A bad stop bit takes priority over any parity result.
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end else begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_q != ^shift_q) begin
              perr_d = 1'b1;
            end else begin
              byte_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            byte_d  = shift_q;
            valid_d = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_if.rx_byte   = byte_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = perr_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
//   Scoreboard bench for uart_rx_core at 16 clocks per bit. Each frame sent
//   pushes its expected outcome (valid / frame error / parity error plus the
//   byte rx_byte must show) into a queue; a monitor pops and compares on
//   every strobe. Directed frames are followed by random ones.
//   Honours UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;

  localparam logic [1:0] K_VALID  = 2'd0;
  localparam logic [1:0] K_FRAME  = 2'd1;
  localparam logic [1:0] K_PARITY = 2'd2;
  localparam logic [1:0] K_BAD    = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rstn;
  logic rx;

  uart_rx_core_if rx_if ();

  uart_rx_core #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .rx    (rx),
    .rx_if (rx_if)
  );

  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         checks;
  int         errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: the frame's fate follows directly from its stop bit and
  // whether the parity bit makes the total count of ones even.
  task automatic push_expected(input logic [7:0] data, input logic stop_bit,
                               input logic par_bit);
    exp_t e;
    logic parity_ok;
`ifdef UART_RX_PARITY_EN
    parity_ok = (($countones(data) + int'(par_bit)) % 2) == 0;
`else
    parity_ok = 1'b1 | par_bit;
`endif
    if (!stop_bit) begin
      e.kind = K_FRAME;
      e.data = last_good;
    end else if (!parity_ok) begin
      e.kind = K_PARITY;
      e.data = last_good;
    end else begin
      e.kind    = K_VALID;
      e.data    = data;
      last_good = data;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                input logic par_bit);
    push_expected(data, stop_bit, par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation,
  // strobes must be exclusive and never on two consecutive cycles.
  initial begin
    logic prev_any;
    prev_any = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_if.rx_valid || rx_if.frame_err || rx_if.parity_err) begin
        logic [1:0] act_kind;
        exp_t       e;
        int         n;
        n = int'(rx_if.rx_valid) + int'(rx_if.frame_err) + int'(rx_if.parity_err);
        if (n > 1)                act_kind = K_BAD;
        else if (rx_if.rx_valid)  act_kind = K_VALID;
        else if (rx_if.frame_err) act_kind = K_FRAME;
        else                      act_kind = K_PARITY;
        check_output("strobe_not_repeated", 32'(prev_any), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_strobe: got kind %0d byte 0x%0h, expected no strobe",
                   act_kind, rx_if.rx_byte);
        end else begin
          e = exp_q.pop_front();
          check_output("strobe_kind", 32'(act_kind), 32'(e.kind));
          check_output("rx_byte", 32'(rx_if.rx_byte), 32'(e.data));
        end
        prev_any = 1'b1;
      end else begin
        prev_any = 1'b0;
      end
    end
  end

  initial begin
    int   waited;
    logic busy_seen;
    checks    = 0;
    errors    = 0;
    last_good = 8'h00;
    rx        = 1'b1;
    rstn      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_rx_byte", 32'(rx_if.rx_byte), 32'd0);
    check_output("reset_strobes", 32'({rx_if.rx_valid, rx_if.frame_err, rx_if.parity_err}), 32'd0);
    check_output("reset_busy", 32'(rx_if.busy), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single good byte
    apply_stimulus(8'h31, 1'b1, even_par(8'h31));
    drive_bit(1'b1);
    check_output("busy_after_0x31", 32'(rx_if.busy), 32'd0);

    // Short low glitch must be rejected with no strobe
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) begin
      @(negedge clk);
      if (rx_if.busy) busy_seen = 1'b1;
    end
    check_output("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check_output("glitch_busy_idle", 32'(rx_if.busy), 32'd0);

    // Bad stop bit, held low for five bit times, then a good byte
    apply_stimulus(8'h55, 1'b0, even_par(8'h55));
    repeat (5) drive_bit(1'b0);
    check_output("break_busy", 32'(rx_if.busy), 32'd1);
    repeat (2) drive_bit(1'b1);
    check_output("break_released", 32'(rx_if.busy), 32'd0);
    apply_stimulus(8'h32, 1'b1, even_par(8'h32));

    // Back-to-back frames, zero idle gap
    apply_stimulus(8'h30, 1'b1, even_par(8'h30));
    apply_stimulus(8'h32, 1'b1, even_par(8'h32));
    apply_stimulus(8'h33, 1'b1, even_par(8'h33));
    drive_bit(1'b1);

    // Reset during data bit 4 of 0x41
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h41 >> i));
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rstn = 1'b0;
    rx   = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    last_good = 8'h00;
    check_output("midreset_rx_byte", 32'(rx_if.rx_byte), 32'd0);
    check_output("midreset_busy", 32'(rx_if.busy), 32'd0);
    check_output("midreset_strobes", 32'({rx_if.rx_valid, rx_if.frame_err, rx_if.parity_err}), 32'd0);
    repeat (2) drive_bit(1'b1);
    apply_stimulus(8'h41, 1'b1, even_par(8'h41));

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit, then correct parity bit
    apply_stimulus(8'h33, 1'b1, 1'b1);
    apply_stimulus(8'h33, 1'b1, 1'b0);
`endif

    // Random traffic
    for (int f = 0; f < 40; f++) begin
      logic [7:0] d;
      int         r;
      d = 8'($urandom_range(0, 255));
      r = int'($urandom_range(0, 99));
      if (r < 65) begin
        apply_stimulus(d, 1'b1, even_par(d));
        repeat ($urandom_range(0, 1)) drive_bit(1'b1);
      end else if (r < 80) begin
        apply_stimulus(d, 1'b1, ~even_par(d));
        repeat ($urandom_range(0, 1)) drive_bit(1'b1);
      end else begin
        apply_stimulus(d, 1'b0, 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) drive_bit(1'b0);
        repeat ($urandom_range(1, 3)) drive_bit(1'b1);
      end
    end

    // Drain outstanding expectations within a bounded time
    waited = 0;
    while (exp_q.size() != 0 && waited < 20 * CPB) begin
      @(negedge clk);
      waited++;
    end
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    drive_bit(1'b1);
    check_output("final_busy", 32'(rx_if.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
